// File: rtl/uart_frame_rx.sv
// Rebuilds the 32-bit pong game-state word from UART bytes (MSB byte first, bit 31 marks frame start).
// Optional link watchdog compiled in with `define UART_LINK_WDG_EN.
module uart_frame_rx #(
  parameter int GAP_CYCLES = 100000,
  parameter int LINK_TICKS = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_done_tick,
  input  logic [7:0]  rx_data,
  input  logic        timing_tick,
  output logic [31:0] rx_buf,
  output logic        frame_valid,
  output logic [7:0]  frame_err_cnt,
  output logic        link_lost
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t           state_reg;
  logic [1:0]       byte_cnt_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic [31:0]      shift_reg;
  logic             pending_reg;
  logic [31:0]      rx_buf_reg;
  logic             frame_valid_reg;
  logic [7:0]       err_cnt_reg;

  assign rx_buf        = rx_buf_reg;
  assign frame_valid   = frame_valid_reg;
  assign frame_err_cnt = err_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      byte_cnt_reg    <= 2'd0;
      gap_cnt_reg     <= '0;
      shift_reg       <= 32'h0;
      pending_reg     <= 1'b0;
      rx_buf_reg      <= 32'h0;
      frame_valid_reg <= 1'b0;
      err_cnt_reg     <= 8'h0;
    end else begin
      // Completed word is published one edge after the 4th byte, all 32 bits at once.
      frame_valid_reg <= pending_reg;
      pending_reg     <= 1'b0;
      if (pending_reg) begin
        rx_buf_reg <= shift_reg;
      end

      case (state_reg)
        IDLE: begin
          gap_cnt_reg <= '0;
          if (rx_done_tick) begin
            if (rx_data[7]) begin
              shift_reg    <= {rx_data, 24'h0};
              byte_cnt_reg <= 2'd1;
              state_reg    <= COLLECT;
            end else if (err_cnt_reg != 8'hFF) begin
              err_cnt_reg <= err_cnt_reg + 8'd1;
            end
          end
        end

        COLLECT: begin
          if (rx_done_tick) begin
            gap_cnt_reg <= '0;
            case (byte_cnt_reg)
              2'd1:    shift_reg[23:16] <= rx_data;
              2'd2:    shift_reg[15:8]  <= rx_data;
              default: shift_reg[7:0]   <= rx_data;
            endcase
            if (byte_cnt_reg == 2'd3) begin
              byte_cnt_reg <= 2'd0;
              pending_reg  <= 1'b1;
              state_reg    <= IDLE;
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 2'd1;
            end
          end else if (gap_cnt_reg == GAP_LAST) begin
            // Byte arriving on this same cycle would have won; otherwise drop the partial frame.
            gap_cnt_reg  <= '0;
            byte_cnt_reg <= 2'd0;
            state_reg    <= IDLE;
            if (err_cnt_reg != 8'hFF) begin
              err_cnt_reg <= err_cnt_reg + 8'd1;
            end
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef UART_LINK_WDG_EN
  localparam int TICK_W = $clog2(LINK_TICKS + 1);
  localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(LINK_TICKS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(LINK_TICKS - 1);

  logic [TICK_W-1:0] tick_cnt_reg;
  logic              link_lost_reg;

  assign link_lost = link_lost_reg;

  // A good frame clears the watchdog even if a timing tick lands on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_reg  <= '0;
      link_lost_reg <= 1'b0;
    end else if (pending_reg) begin
      tick_cnt_reg  <= '0;
      link_lost_reg <= 1'b0;
    end else if (timing_tick && tick_cnt_reg != TICK_MAX) begin
      tick_cnt_reg <= tick_cnt_reg + 1'b1;
      if (tick_cnt_reg == TICK_LAST) begin
        link_lost_reg <= 1'b1;
      end
    end
  end
`else
  logic unused_timing_tick;
  assign unused_timing_tick = timing_tick;
  assign link_lost = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: expected frames queued when the 4th byte is sent, popped on frame_valid.
module tb_uart_frame_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_done_tick = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        timing_tick = 1'b0;
  logic [31:0] rx_buf;
  logic        frame_valid;
  logic [7:0]  frame_err_cnt;
  logic        link_lost;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_tick_cyc = 0;

`ifdef UART_LINK_WDG_EN
  localparam logic WDG_ON = 1'b1;
`else
  localparam logic WDG_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] word;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  uart_frame_rx #(.GAP_CYCLES(50), .LINK_TICKS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .timing_tick  (timing_tick),
    .rx_buf       (rx_buf),
    .frame_valid  (frame_valid),
    .frame_err_cnt(frame_err_cnt),
    .link_lost    (link_lost)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every frame_valid must match the oldest queued frame, one cycle after its last byte.
  always @(negedge clk) begin
    if (rst_n && frame_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL spurious_frame_valid: rx_buf=%h at cycle %0d, required no pulse", rx_buf, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rx_buf !== e.word || cyc !== e.cyc) begin
          miscompares++;
          $display("FAIL frame_word: rx_buf=%h cycle=%0d, required %h at cycle %0d", rx_buf, cyc, e.word, e.cyc);
        end else begin
          $display("frame %h at cycle %0d ok", rx_buf, cyc);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL time_limit: simulation still running, required completion");
    $fatal(1, "time limit");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done_tick = 1'b1;
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0;
    last_tick_cyc = cyc;
  endtask

  task automatic pulse_tick();
    timing_tick = 1'b1;
    @(posedge clk);
    #1;
    timing_tick = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] w, input int spacing);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8]);
      if (i < 3) idle(spacing - 1);
    end
    e.word = w;
    e.cyc  = last_tick_cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic check_err(input string name, input logic [7:0] req);
    vectors++;
    if (frame_err_cnt !== req) begin
      miscompares++;
      $display("FAIL %s: frame_err_cnt=%h, required %h", name, frame_err_cnt, req);
    end else begin
      $display("%s: frame_err_cnt=%h ok", name, frame_err_cnt);
    end
  endtask

  task automatic check_buf(input string name, input logic [31:0] req);
    vectors++;
    if (rx_buf !== req) begin
      miscompares++;
      $display("FAIL %s: rx_buf=%h, required %h", name, rx_buf, req);
    end else begin
      $display("%s: rx_buf=%h ok", name, rx_buf);
    end
  endtask

  task automatic check_lost(input string name, input logic req);
    vectors++;
    if (link_lost !== req) begin
      miscompares++;
      $display("FAIL %s: link_lost=%b, required %b", name, link_lost, req);
    end else begin
      $display("%s: link_lost=%b ok", name, link_lost);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    check_buf("reset_rx_buf", 32'h0);
    vectors++;
    if (frame_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_frame_valid: frame_valid=%b, required 0", frame_valid);
    end else begin
      $display("reset_frame_valid: ok");
    end
    check_err("reset_err_cnt", 8'h00);
    check_lost("reset_link_lost", 1'b0);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_basic_frame();
    do_reset();
    send_frame(32'hA5B3C7D1, 20);
    idle(2);
    check_buf("basic_rx_buf", 32'hA5B3C7D1);
    check_err("basic_err", 8'h00);
  endtask

  task automatic test_bad_start();
    do_reset();
    send_byte(8'h12);
    idle(5);
    check_err("bad_start_err", 8'h01);
    check_buf("bad_start_buf_untouched", 32'h0);
    send_frame(32'h8000040F, 5);
    idle(2);
    check_buf("bad_start_rx_buf", 32'h8000040F);
    check_err("bad_start_err_after", 8'h01);
  endtask

  task automatic test_gap_timeout();
    do_reset();
    send_frame(32'hDEADBEEF, 3);
    idle(2);
    send_byte(8'h9F);
    idle(19);
    send_byte(8'h11);
    idle(60);
    check_err("gap_timeout_err", 8'h01);
    check_buf("gap_timeout_buf_held", 32'hDEADBEEF);
    send_frame(32'hC0010203, 20);
    idle(2);
    check_buf("gap_timeout_rx_buf", 32'hC0010203);
    check_err("gap_timeout_err_after", 8'h01);
  endtask

  task automatic test_gap_boundary();
    exp_t e;
    do_reset();
    send_byte(8'h9F);
    idle(19);
    send_byte(8'h11);
    idle(49);
    send_byte(8'h22);
    idle(19);
    send_byte(8'h33);
    e.word = 32'h9F112233;
    e.cyc  = last_tick_cyc + 1;
    exp_q.push_back(e);
    idle(2);
    check_buf("gap_boundary_rx_buf", 32'h9F112233);
    check_err("gap_boundary_err", 8'h00);
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send_frame(32'h87654321, 2);
    idle(2);
    send_byte(8'hA5);
    idle(3);
    send_byte(8'hB3);
    idle(3);
    do_reset();
    check_buf("mid_reset_rx_buf_cleared", 32'h0);
    send_frame(32'h81223344, 4);
    idle(3);
    check_buf("mid_reset_rx_buf", 32'h81223344);
    check_err("mid_reset_err", 8'h00);
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(32'hF0E1D2C3, 1);
    send_frame(32'h8A0B0C0D, 1);
    idle(3);
    check_buf("back_to_back_rx_buf", 32'h8A0B0C0D);
    check_err("back_to_back_err", 8'h00);
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      send_byte(8'($urandom_range(0, 127)));
      if (i == 253) check_err("sat_err_254", 8'hFE);
      if (i == 254) check_err("sat_err_255", 8'hFF);
    end
    idle(2);
    check_err("sat_err_300", 8'hFF);
    check_buf("sat_rx_buf", 32'h0);
  endtask

  task automatic test_watchdog();
    exp_t e;
    do_reset();
    for (int i = 0; i < 3; i++) pulse_tick();
    check_lost("wdg_three_ticks", 1'b0);
    pulse_tick();
    check_lost("wdg_four_ticks", WDG_ON);
    send_byte(8'h81);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    e.word = 32'h81020304;
    e.cyc  = last_tick_cyc + 1;
    exp_q.push_back(e);
    check_lost("wdg_before_frame_valid", WDG_ON);
    // timing tick on the same edge as frame_valid: the clear must win
    pulse_tick();
    check_lost("wdg_cleared_on_frame", 1'b0);
    for (int i = 0; i < 3; i++) pulse_tick();
    check_lost("wdg_clear_won", 1'b0);
    pulse_tick();
    check_lost("wdg_relost", WDG_ON);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_bad_start();
    test_gap_timeout();
    test_gap_boundary();
    test_reset_mid_frame();
    test_back_to_back();
    test_saturation();
    test_watchdog();
    idle(3);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_frames: %0d frames never published, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- Remote-end frame assembler for the inter-board pong link.
- Takes bytes from the UART receiver (rx_data and rx_done_tick) and rebuilds the 32-bit game-state word that the peer sends MSB byte first.
- The word is {1'b1, y_pad[9:0], y_ball[9:0], x_ball[10:0]}; bit 31 marks the start of a frame.
- Publishes the word atomically on rx_buf for the position muxes, with frame-error accounting and inter-byte gap resynchronisation.

Parameters:
- GAP_CYCLES, 100000, maximum clk cycles allowed between consecutive bytes of one frame before the partial frame is dropped.
- LINK_TICKS, 30, number of timing_tick pulses without a good frame before link_lost asserts (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset.
- rx_done_tick  input  1  one-cycle strobe: rx_data holds a new byte.
- rx_data  input  8  received byte.
- timing_tick  input  1  frame-rate tick (one pulse per video frame).
- rx_buf  output  32  last complete, valid frame word.
- frame_valid  output  1  one-cycle pulse when rx_buf updates.
- frame_err_cnt  output  8  saturating count of dropped bytes and frames.
- link_lost  output  1  no valid frame within LINK_TICKS ticks (optional feature; otherwise constant 0).

Behaviour:
- Reset (rst_n=0 sampled on a clk edge):
  - state=IDLE; byte_cnt=0; gap_cnt=0; shift register=0.
  - rx_buf=32'h0, frame_valid=0, frame_err_cnt=0, link_lost=0.
  - Reset mid-frame discards the partial frame and does not count it as an error.
- FSM states: IDLE, COLLECT.
- IDLE:
  - On rx_done_tick with rx_data[7]=1: load rx_data into shift[31:24], byte_cnt=1, gap_cnt=0, go to COLLECT.
  - On rx_done_tick with rx_data[7]=0: discard the byte, frame_err_cnt+1, stay in IDLE.
- COLLECT:
  - Each rx_done_tick shifts the byte in below the previous ones (second byte to [23:16], third to [15:8], fourth to [7:0]), byte_cnt+1, gap_cnt=0.
  - Byte MSB is not checked in COLLECT.
  - On the 4th byte: go to IDLE. On the next clk edge rx_buf = assembled word and frame_valid=1 for exactly one cycle.
  - Latency: 1 cycle from the 4th rx_done_tick to rx_buf/frame_valid.
- Gap timeout:
  - In COLLECT, gap_cnt increments on every cycle with rx_done_tick=0.
  - When gap_cnt reaches GAP_CYCLES: drop the partial frame, frame_err_cnt+1, return to IDLE; rx_buf is unchanged.
  - If rx_done_tick coincides with the cycle gap_cnt would reach the limit, the byte is accepted and the timeout does not fire.
  - gap_cnt is held at 0 in IDLE; its width is $clog2(GAP_CYCLES+1).
- rx_buf is never partially updated; it holds the last good word indefinitely.
- frame_err_cnt saturates at 8'hFF; it never wraps.
- timing_tick has no effect on assembly.

Optional Feature:
- Macro: UART_LINK_WDG_EN.
- With the macro defined:
  - A tick counter increments on each timing_tick and clears to 0 on each frame_valid.
  - When the counter reaches LINK_TICKS, link_lost=1 and the counter holds there.
  - link_lost clears to 0 on the same edge that frame_valid asserts.
  - If frame_valid and timing_tick coincide, the clear wins.
- Without the macro: no counter logic is compiled; link_lost is tied to 0.

Test Plan:
- Bytes A5,B3,C7,D1 spaced 20 cycles -> rx_buf=32'hA5B3C7D1 and frame_valid high for 1 cycle, 1 clk after the D1 tick; frame_err_cnt=0.
- Byte 12 then frame 80,00,04,0F -> frame_err_cnt=1; rx_buf=32'h8000040F; the 12 byte never appears in rx_buf.
- GAP_CYCLES=50: send 9F,11, wait 60 cycles, then frame C0,01,02,03 -> frame_err_cnt=1; rx_buf=32'hC0010203. Repeat with the 3rd byte arriving exactly at gap cycle 50 -> byte accepted, no error.
- Send A5,B3, assert rst_n=0 for 1 cycle, then frame 81,22,33,44 -> rx_buf=32'h81223344; frame_err_cnt=0; no spurious frame_valid.
- 300 bytes with MSB=0 -> frame_err_cnt saturates at 8'hFF; rx_buf remains 0.
- UART_LINK_WDG_EN, LINK_TICKS=4: 4 timing_ticks with no frame -> link_lost=1; then one valid frame -> link_lost=0 on the frame_valid edge. Without the macro -> link_lost stays 0 throughout.
